// File: rtl/ysyx_22040175_ifu_prefetch_pkg.sv
// Shared constants for the prefetching instruction-fetch unit.
//  CpuWidth / InstWidth / ResetPc / IbufDepth : default geometry of the fetch unit
//  S_BOOT / S_RUN                             : fetch FSM encodings
//  cnt_width()                                : width of counters that must hold 0..depth
package ysyx_22040175_ifu_prefetch_pkg;

  localparam int unsigned CpuWidth  = 64;
  localparam int unsigned InstWidth = 32;
  localparam logic [63:0] ResetPc   = 64'h8000_0000;
  localparam int unsigned IbufDepth = 4;

  typedef logic [0:0] fetch_state_t;

  // BOOT holds off requests for one cycle after reset.
  localparam fetch_state_t S_BOOT = 1'b0;
  localparam fetch_state_t S_RUN  = 1'b1;

  // One spare bit so counter arithmetic cannot wrap before the assertions see it.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1) + 1;
  endfunction

endpackage

// File: rtl/ysyx_22040175_ifu_prefetch_if.sv
// Bus bundle of the fetch unit: instruction-memory request/response, redirect input and
// the decoder-side instruction port.
//  master : fetch-unit side (drives requests and the instruction port)
//  slave  : environment side (memory, branch unit, decoder)
interface ysyx_22040175_ifu_prefetch_if
  import ysyx_22040175_ifu_prefetch_pkg::*;
#(
  parameter int unsigned XLEN = CpuWidth,
  parameter int unsigned ILEN = InstWidth
) ();

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [ILEN-1:0] imem_rsp_data;
  logic            imem_rsp_err;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            inst_valid;
  logic            inst_ready;
  logic [ILEN-1:0] inst_data;
  logic [XLEN-1:0] inst_pc;
  logic            inst_err;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid, imem_rsp_data, imem_rsp_err,
    input  redirect_valid, redirect_pc,
    output inst_valid, inst_data, inst_pc, inst_err,
    input  inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid, imem_rsp_data, imem_rsp_err,
    output redirect_valid, redirect_pc,
    input  inst_valid, inst_data, inst_pc, inst_err,
    output inst_ready
  );

endinterface

// File: rtl/ysyx_22040175_sync_fifo.sv
// Synchronous FIFO with registered storage and synchronous flush.
//  clk, rst      : clock, synchronous active-high reset
//  flush         : empties the FIFO at the next edge (overrides push/pop)
//  push/push_data: write request; accepted when not full, or when full and popping
//  pop/pop_data  : pop_data shows the head; pop is ignored while empty
//  full/empty    : occupancy flags
//  count         : number of stored entries (0..DEPTH)
// DEPTH must be a power of two so the pointers wrap naturally.
module ysyx_22040175_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             push_en;
  logic             pop_en;

  assign empty    = (count_q == '0);
  assign full     = (count_q == (AW+1)'(DEPTH));
  assign count    = count_q;
  assign pop_en   = pop && !empty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign push_en  = push && (!full || pop_en);
  assign pop_data = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_en) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop_en) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_q + (AW+1)'(push_en) - (AW+1)'(pop_en);
    end
  end

  // Storage carries no reset; entries are only observed once counted.
  always_ff @(posedge clk) begin
    if (push_en && !flush) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/ysyx_22040175_ifu_prefetch.sv
// Prefetching instruction-fetch unit.
// Owns the fetch PC, issues pipelined word fetches to instruction memory, buffers the
// in-order responses and hands them to the decoder. A redirect flushes buffered work and
// discards every response still owed for requests issued before it.
//  clk, rst : clock, synchronous active-high reset
//  bus      : master side of ysyx_22040175_ifu_prefetch_if
//             imem_req_*  fetch request (valid/ready, word-aligned addr)
//             imem_rsp_*  in-order response (data, access fault), no backpressure
//             redirect_*  flush and restart at redirect_pc (low two bits ignored)
//             inst_*      head of the instruction buffer (valid/ready, data, pc, fault)
module ysyx_22040175_ifu_prefetch
  import ysyx_22040175_ifu_prefetch_pkg::*;
#(
  parameter int unsigned     XLEN       = CpuWidth,
  parameter logic [XLEN-1:0] RESET_PC   = XLEN'(ResetPc),
  parameter int unsigned     FIFO_DEPTH = IbufDepth,
  parameter int unsigned     ILEN       = InstWidth
) (
  input  logic                         clk,
  input  logic                         rst,
  ysyx_22040175_ifu_prefetch_if.master bus
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = cnt_width(FIFO_DEPTH);
  localparam int unsigned EW = XLEN + 1 + ILEN;

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  // A request stalled across a redirect keeps its old address until accepted.
  logic            stale_q, stale_d;
  logic [XLEN-1:0] stale_addr_q, stale_addr_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_d;

  logic            redirect;
  logic            req_valid;
  logic [XLEN-1:0] req_addr;
  logic            fire;
  logic            stalled;
  logic            rsp;
  logic [CW:0]     occupancy;
  logic            credit_ok;

  logic            ibuf_push;
  logic            ibuf_full;
  logic            ibuf_empty;
  logic [AW:0]     ibuf_count;
  logic [EW-1:0]   ibuf_wdata;
  logic [EW-1:0]   ibuf_rdata;

  logic            shq_full;
  logic            shq_empty;
  logic [AW:0]     shq_count;
  logic [XLEN-1:0] rsp_pc;

  assign redirect = bus.redirect_valid;
  assign rsp      = bus.imem_rsp_valid;

  // Every outstanding request owns a buffer slot, so responses never meet a full buffer.
  // Without a fire, inflight + count can only shrink, so an offered request stays offered.
  assign occupancy = (CW+1)'(inflight_q) + (CW+1)'(ibuf_count);
  assign credit_ok = (occupancy < (CW+1)'(FIFO_DEPTH));

  assign req_valid = (state_q == S_RUN) && (stale_q || credit_ok);
  assign req_addr  = stale_q ? stale_addr_q : fetch_pc_q;
  assign fire      = req_valid && bus.imem_req_ready;
  assign stalled   = req_valid && !bus.imem_req_ready;

  // A response in the redirect cycle is older than the redirect and is discarded.
  assign ibuf_push  = rsp && !redirect && (drop_cnt_q == '0);
  assign ibuf_wdata = {rsp_pc, bus.imem_rsp_err, bus.imem_rsp_data};

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    stale_d      = stale_q;
    stale_addr_d = stale_addr_q;
    inflight_d   = inflight_q + CW'(fire) - CW'(rsp);
    drop_cnt_d   = drop_cnt_q;

    if (state_q == S_BOOT) begin
      state_d = S_RUN;
    end

    // A stale request's address was already consumed from fetch_pc.
    if (fire && !stale_q) begin
      fetch_pc_d = fetch_pc_q + XLEN'(4);
    end

    if (fire) begin
      stale_d = 1'b0;
    end

    if (redirect) begin
      fetch_pc_d = {bus.redirect_pc[XLEN-1:2], 2'b00};
      // Everything outstanding after this edge predates the redirect.
      drop_cnt_d = inflight_d;
      if (stalled) begin
        stale_d      = 1'b1;
        stale_addr_d = req_addr;
      end
    end else begin
      drop_cnt_d = drop_cnt_q - CW'(rsp && (drop_cnt_q != '0)) + CW'(fire && stale_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_BOOT;
      fetch_pc_q   <= RESET_PC;
      stale_q      <= 1'b0;
      stale_addr_q <= '0;
      inflight_q   <= '0;
      drop_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      stale_q      <= stale_d;
      stale_addr_q <= stale_addr_d;
      inflight_q   <= inflight_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  // Instruction buffer: {pc, err, data}, flushed by redirect.
  ysyx_22040175_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_ibuf (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect),
    .push      (ibuf_push),
    .push_data (ibuf_wdata),
    .pop       (bus.inst_ready),
    .pop_data  (ibuf_rdata),
    .full      (ibuf_full),
    .empty     (ibuf_empty),
    .count     (ibuf_count)
  );

  // Address shadow queue: one entry per outstanding request, popped by every response
  // (dropped or not), so its head is always the PC of the arriving response.
  ysyx_22040175_sync_fifo #(
    .WIDTH (XLEN),
    .DEPTH (FIFO_DEPTH)
  ) u_addr_shadow (
    .clk       (clk),
    .rst       (rst),
    .flush     (1'b0),
    .push      (fire),
    .push_data (req_addr),
    .pop       (rsp),
    .pop_data  (rsp_pc),
    .full      (shq_full),
    .empty     (shq_empty),
    .count     (shq_count)
  );

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = req_addr;
  assign bus.inst_valid     = !ibuf_empty;
  assign bus.inst_pc        = ibuf_rdata[EW-1 -: XLEN];
  assign bus.inst_err       = ibuf_rdata[ILEN];
  assign bus.inst_data      = ibuf_rdata[ILEN-1:0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (inflight_q <= CW'(FIFO_DEPTH));
      assert (!(rsp && (inflight_q == '0)));
      assert (!(rsp && shq_empty));
      assert (!(fire && shq_full));
      assert (!(ibuf_push && ibuf_full));
      assert (CW'(shq_count) == inflight_q);
    end
  end

endmodule

// File: tb/tb_ysyx_22040175_ifu_prefetch.sv
// Self-checking bench for ysyx_22040175_ifu_prefetch. The reference model tags each
// request with the redirect epoch it was first offered in; a response is delivered only
// if its epoch is still current and no redirect coincides with it.
module tb_ysyx_22040175_ifu_prefetch;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned ILEN  = 32;
  localparam int unsigned DEPTH = 4;
  localparam logic [63:0] RST_PC = 64'h8000_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ysyx_22040175_ifu_prefetch_if #(.XLEN(XLEN), .ILEN(ILEN)) bus ();

  ysyx_22040175_ifu_prefetch #(
    .XLEN       (XLEN),
    .RESET_PC   (RST_PC),
    .FIFO_DEPTH (DEPTH),
    .ILEN       (ILEN)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [63:0] addr;
    int          epoch;
    int          due;
    logic [31:0] data;
    logic        err;
  } mreq_t;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] data;
    logic        err;
  } inst_t;

  mreq_t memq[$];
  inst_t expq[$];

  int total = 0;
  int bad   = 0;
  int cyc = 0;
  int since_rst = 0;
  int cur_epoch = 0;
  int held_epoch = 0;
  bit held = 0;
  bit prev_rst = 0;
  logic [63:0] held_addr = '0;
  logic [63:0] model_pc = RST_PC;
  int fires = 0;

  // Stimulus knobs
  int p_ready = 100, p_rsp = 100, p_iready = 100, p_redir = 0, p_err = 0;
  int lat_lo = 1, lat_hi = 1;
  logic [63:0] err_addr = '0;
  logic [63:0] ready_block = '0;
  bit force_redir = 0;
  logic [63:0] force_pc = '0;
  bit lit_a = 0;
  logic [63:0] lit_redir_pc = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_data(input logic [63:0] a);
    return a[31:0] ^ 32'hA5A5_0F0F ^ {a[47:32], 16'h0};
  endfunction

  task automatic step(input bit do_rst);
    bit rdy, rv, redir, iready, fire, keep;
    int ep;
    logic [63:0] rpc;
    mreq_t e;
    inst_t it;
    @(negedge clk);
    rdy    = !do_rst && ($urandom_range(99) < p_ready);
    if (ready_block != '0 && bus.imem_req_addr == ready_block) rdy = 1'b0;
    rv     = !do_rst && memq.size() > 0 && memq[0].due <= cyc && ($urandom_range(99) < p_rsp);
    redir  = !do_rst && (force_redir || ($urandom_range(999) < p_redir));
    rpc    = force_redir ? force_pc : RST_PC + 64'($urandom_range(0, 65535));
    iready = ($urandom_range(99) < p_iready);
    rst = do_rst;
    bus.imem_req_ready = rdy;
    bus.imem_rsp_valid = rv;
    bus.imem_rsp_data  = rv ? memq[0].data : $urandom;
    bus.imem_rsp_err   = rv ? memq[0].err : 1'b0;
    bus.redirect_valid = redir;
    bus.redirect_pc    = rpc;
    bus.inst_ready     = iready;
    #1;
    if (do_rst) begin
      if (prev_rst) begin
        check("rst_req_valid", 64'(bus.imem_req_valid), 64'd0);
        check("rst_inst_valid", 64'(bus.inst_valid), 64'd0);
      end
      memq.delete();
      expq.delete();
      held = 0;
      model_pc = RST_PC;
      since_rst = 0;
      fires = 0;
      cur_epoch++;
    end else begin
      // Request side
      if (since_rst == 0) begin
        check("boot_no_req", 64'(bus.imem_req_valid), 64'd0);
      end else if (held) begin
        check("hold_valid", 64'(bus.imem_req_valid), 64'd1);
        check("hold_addr", bus.imem_req_addr, held_addr);
      end else begin
        check("credit", 64'(bus.imem_req_valid), 64'(memq.size() + expq.size() < DEPTH));
        if (bus.imem_req_valid) check("req_addr", bus.imem_req_addr, model_pc);
      end
      // Instruction side
      check("inst_valid", 64'(bus.inst_valid), 64'(expq.size() > 0));
      if (expq.size() > 0) begin
        check("inst_pc", bus.inst_pc, expq[0].pc);
        check("inst_data", 64'(bus.inst_data), 64'(expq[0].data));
        check("inst_err", 64'(bus.inst_err), 64'(expq[0].err));
      end
      // Hand-computed pins of the first delivered instructions after reset
      if (lit_a && since_rst >= 3 && since_rst <= 5) begin
        check("lit_valid", 64'(bus.inst_valid), 64'd1);
        case (since_rst)
          3: begin
            check("lit_pc0", bus.inst_pc, 64'h0000_0000_8000_0000);
            check("lit_err0", 64'(bus.inst_err), 64'd0);
          end
          4: begin
            check("lit_pc1", bus.inst_pc, 64'h0000_0000_8000_0004);
            check("lit_err1", 64'(bus.inst_err), 64'd1);
          end
          default: begin
            check("lit_pc2", bus.inst_pc, 64'h0000_0000_8000_0008);
            check("lit_err2", 64'(bus.inst_err), 64'd0);
          end
        endcase
      end
      if (lit_redir_pc != '0 && bus.inst_valid) begin
        check("redir_first_pc", bus.inst_pc, lit_redir_pc);
        lit_redir_pc = '0;
      end
      // Model update for the coming edge
      fire = bus.imem_req_valid && rdy;
      ep = held ? held_epoch : cur_epoch;
      if (fire) begin
        e.addr  = bus.imem_req_addr;
        e.epoch = ep;
        e.due   = cyc + $urandom_range(lat_hi, lat_lo);
        e.data  = mem_data(bus.imem_req_addr);
        e.err   = (bus.imem_req_addr == err_addr) || ($urandom_range(99) < p_err);
        memq.push_back(e);
        fires++;
        if (ep == cur_epoch) model_pc = model_pc + 64'd4;
      end
      if (bus.imem_req_valid && !rdy) begin
        held = 1;
        held_addr = bus.imem_req_addr;
        held_epoch = ep;
      end else begin
        held = 0;
      end
      keep = 0;
      if (rv) begin
        e = memq.pop_front();
        keep = !redir && (e.epoch == cur_epoch);
        it.pc = e.addr;
        it.data = e.data;
        it.err = e.err;
      end
      if (redir) begin
        expq.delete();
        cur_epoch++;
        model_pc = {rpc[63:2], 2'b00};
      end else begin
        if (iready && expq.size() > 0) void'(expq.pop_front());
        if (keep) expq.push_back(it);
      end
      since_rst++;
    end
    prev_rst = do_rst;
    cyc++;
  endtask

  task automatic do_reset();
    step(1);
    step(1);
  endtask

  initial begin
    bit found;
    rst = 1'b1;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.imem_rsp_err   = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.inst_ready     = 1'b0;

    // Back-to-back fetch with a 1-cycle memory; fault on the second word
    err_addr = 64'h8000_0004;
    lit_a = 1;
    do_reset();
    repeat (12) step(0);
    lit_a = 0;
    err_addr = '0;

    // Reset mid-burst, then stall the decoder: only DEPTH requests may go out
    do_reset();
    p_iready = 0;
    repeat (15) step(0);
    check("fill_limit", 64'(fires), 64'd4);
    check("fill_stop", 64'(bus.imem_req_valid), 64'd0);
    p_iready = 100;
    repeat (12) step(0);

    // Redirect with responses in flight
    lat_lo = 3;
    lat_hi = 3;
    do_reset();
    repeat (5) step(0);
    force_redir = 1;
    force_pc = 64'h8000_1002;
    step(0);
    force_redir = 0;
    lit_redir_pc = 64'h8000_1000;
    repeat (20) step(0);
    check("redir_seen", lit_redir_pc, 64'd0);

    // Redirect while a request is held unaccepted
    lat_lo = 1;
    lat_hi = 1;
    ready_block = 64'h8000_0010;
    do_reset();
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(0);
      found = bus.imem_req_valid && (bus.imem_req_addr == 64'h8000_0010);
    end
    check("hold_reached", 64'(found), 64'd1);
    force_redir = 1;
    force_pc = 64'h8000_2000;
    step(0);
    force_redir = 0;
    step(0);
    check("stale_addr_kept", bus.imem_req_addr, 64'h8000_0010);
    check("stale_valid_kept", 64'(bus.imem_req_valid), 64'd1);
    step(0);
    ready_block = '0;
    lit_redir_pc = 64'h8000_2000;
    repeat (20) step(0);
    check("redir2_seen", lit_redir_pc, 64'd0);

    // Randomized traffic
    p_ready = 70;
    p_rsp = 75;
    p_iready = 60;
    p_redir = 40;
    p_err = 10;
    lat_lo = 1;
    lat_hi = 4;
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(999) < 4) do_reset();
      else step(0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
